// File: rtl/uart_rx_ctrl.sv
// Purpose: control/buffering front-end for the MiniUart rx_unit: baud sample
//          enable, rs/over_read byte capture into a small FIFO, CPU registers.
// Latency: rx_rs seen at edge N -> byte visible in FIFO after edge N+1;
//          rx_over_read high for the cycle after N+1.
// Backpressure: a full FIFO drops the byte and sets sticky overrun, unless
//               a DATA pop lands in the same cycle as the push.
// Ports:
//   clk, rst           clock / asynchronous active-high reset
//   addr, rd, wr,      CPU register bus (0 DATA, 1 STATUS, 2 DIVISOR, 3 CTRL);
//   wdata, rdata       rdata is combinational from addr and current state
//   irq                level interrupt: CTRL.ien & FIFO not empty
//   rx_en              sample-enable pulse to rx_unit, period DIV+1
//   rx_data, rx_rs     byte and byte-available level from rx_unit
//   rx_over_read       registered one-cycle byte-consumed pulse to rx_unit
module uart_rx_ctrl #(
   parameter logic [15:0] DIV_RESET  = 16'd26,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  addr,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq,
   output logic        rx_en,
   input  logic [7:0]  rx_data,
   input  logic        rx_rs,
   output logic        rx_over_read
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, CAPT, CLR, WAIT} state_t;

   state_t          state;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [15:0]     div;
   logic [15:0]     cnt;
   logic            en;
   logic            ien;
   logic            overrun;

   logic            not_empty;
   logic            full;
   logic            pop;
   logic            push;
   logic            drop;
   logic            flush;
   logic            clr_ovr;
   logic            wr_div;
   logic            wr_ctrl;
   logic [2:0]      count3;
   logic            wdata_unused;

   assign wdata_unused = ^wdata[31:16];

   assign not_empty = (count != '0);
   assign full      = (count == CW'(FIFO_DEPTH));
   assign wr_div    = wr && (addr == 2'd2);
   assign wr_ctrl   = wr && (addr == 2'd3);
   assign flush     = wr_ctrl && wdata[3];
   assign clr_ovr   = wr_ctrl && wdata[2];
   assign pop       = rd && (addr == 2'd0) && not_empty;
   // A full FIFO still accepts the byte when the head leaves in the same cycle.
   // Flush discards the incoming byte without counting it as an overrun.
   assign push      = (state == CAPT) && (!full || pop) && !flush;
   assign drop      = (state == CAPT) && full && !pop && !flush;
   assign count3    = 3'(count);
   assign irq       = ien && not_empty;

   // Baud counter: forced back to zero on any divisor write or disable so a
   // new rate starts with a clean full period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         rx_en <= 1'b0;
      end else if (wr_div || (wr_ctrl && !wdata[0]) || !en) begin
         cnt   <= '0;
         rx_en <= 1'b0;
      end else if (cnt == div) begin
         cnt   <= '0;
         rx_en <= 1'b1;
      end else begin
         cnt   <= cnt + 16'd1;
         rx_en <= 1'b0;
      end
   end

   // Control/status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div     <= DIV_RESET;
         en      <= 1'b0;
         ien     <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (wr_div)
            div <= wdata[15:0];
         if (wr_ctrl) begin
            en  <= wdata[0];
            ien <= wdata[1];
         end
         // A new overrun beats a same-cycle clear.
         overrun <= (overrun && !clr_ovr) || drop;
      end
   end

   // FIFO storage carries no reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= rx_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Capture FSM: one byte per pass; only the IDLE exit is gated by en so a
   // capture already started always finishes its handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         rx_over_read <= 1'b0;
      end else begin
         rx_over_read <= 1'b0;
         case (state)
            IDLE: if (rx_rs && en) state <= CAPT;
            CAPT: begin
               state        <= CLR;
               rx_over_read <= 1'b1;
            end
            CLR:  state <= WAIT;
            WAIT: if (!rx_rs) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         2'd0: if (not_empty) rdata[7:0] = mem[rd_ptr];
         2'd1: begin
            rdata[0]   = not_empty;
            rdata[1]   = full;
            rdata[2]   = overrun;
            rdata[6:4] = count3;
         end
         2'd2: rdata[15:0] = div;
         default: rdata[1:0] = {ien, en};
      endcase
   end

endmodule
